// File: rtl/shift_pkg.sv
// Shared types for the ARM operand-2 barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    localparam int SH_DATA_W = 32;
    localparam int SH_AMT_W  = 8;
    localparam int SH_TAG_W  = 5;

    // Request bundle at the default core width.
    typedef struct packed {
        logic [SH_DATA_W-1:0] data;
        shift_op_e            op;
        logic [SH_AMT_W-1:0]  amt;
        logic                 imm;
        logic                 carry;
        logic [SH_TAG_W-1:0]  tag;
    } shift_req_t;

endpackage

// File: rtl/arm_shift_pipe_core.sv
// Combinational ARM shifter split into a coarse half (decode + upper amount
// bits) and a fine half (lower amount bits + carry select).
module arm_shift_core
    import shift_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int AMT_W  = 8,
    localparam int LOG_W  = $clog2(DATA_W),
    localparam int FINE_B = LOG_W / 2
) (
    input  logic [DATA_W-1:0] i_c_data,
    input  shift_op_e         i_c_op,
    input  logic [AMT_W-1:0]  i_c_amt,
    input  logic              i_c_imm,
    input  logic              i_c_carry,
    output logic [DATA_W:0]   o_c_w,
    output logic [FINE_B-1:0] o_c_fine,
    output logic              o_c_ovr,
    output logic [DATA_W-1:0] o_c_ovr_data,
    output logic              o_c_ovr_c,
    input  logic [DATA_W:0]   i_f_w,
    input  shift_op_e         i_f_op,
    input  logic [FINE_B-1:0] i_f_fine,
    input  logic              i_f_ovr,
    input  logic [DATA_W-1:0] i_f_ovr_data,
    input  logic              i_f_ovr_c,
    output logic [DATA_W-1:0] o_f_data,
    output logic              o_f_carry
);

    localparam logic [AMT_W:0] N_AMT = (AMT_W + 1)'(DATA_W);

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] d,
                                               input logic [LOG_W-1:0]  r);
        logic [2*DATA_W-1:0] dd;
        dd = {d, d} >> r;
        return dd[DATA_W-1:0];
    endfunction

    logic             w_alias, w_rrx;
    logic [AMT_W:0]   w_n;
    logic [LOG_W-1:0] w_s, w_sh_c, w_fine_ext;
    logic [DATA_W:0]  w_fw;

    assign w_alias    = i_c_imm && (i_c_amt == '0) && (i_c_op == SH_LSR || i_c_op == SH_ASR);
    assign w_rrx      = i_c_imm && (i_c_amt == '0) && (i_c_op == SH_ROR);
    assign w_n        = w_alias ? N_AMT : {1'b0, i_c_amt};
    assign w_s        = w_n[LOG_W-1:0];
    assign w_sh_c     = {w_s[LOG_W-1:FINE_B], {FINE_B{1'b0}}};
    assign o_c_fine   = w_s[FINE_B-1:0];
    assign w_fine_ext = {{(LOG_W-FINE_B){1'b0}}, i_f_fine};

    // Cases whose result does not come out of the shift network.
    always_comb begin
        o_c_ovr      = 1'b1;
        o_c_ovr_data = i_c_data;
        o_c_ovr_c    = i_c_carry;
        if (w_rrx) begin
            o_c_ovr_data = {i_c_carry, i_c_data[DATA_W-1:1]};
            o_c_ovr_c    = i_c_data[0];
        end else if (w_n >= N_AMT && i_c_op != SH_ROR) begin
            case (i_c_op)
                SH_LSL: begin
                    o_c_ovr_data = '0;
                    o_c_ovr_c    = (w_n == N_AMT) & i_c_data[0];
                end
                SH_LSR: begin
                    o_c_ovr_data = '0;
                    o_c_ovr_c    = (w_n == N_AMT) & i_c_data[DATA_W-1];
                end
                default: begin
                    o_c_ovr_data = {DATA_W{i_c_data[DATA_W-1]}};
                    o_c_ovr_c    = i_c_data[DATA_W-1];
                end
            endcase
        end else if (w_n != '0) begin
            o_c_ovr = 1'b0;
        end
    end

    // One guard bit rides along so the carry falls out of the same shift.
    always_comb begin
        case (i_c_op)
            SH_LSL:  o_c_w = {1'b0, i_c_data} << w_sh_c;
            SH_LSR:  o_c_w = {i_c_data, 1'b0} >> w_sh_c;
            SH_ASR:  o_c_w = $signed({i_c_data, 1'b0}) >>> w_sh_c;
            default: o_c_w = {1'b0, rotr(i_c_data, w_sh_c)};
        endcase
    end

    always_comb begin
        w_fw      = '0;
        o_f_data  = i_f_w[DATA_W-1:0];
        o_f_carry = 1'b0;
        case (i_f_op)
            SH_LSL: begin
                w_fw      = i_f_w << i_f_fine;
                o_f_data  = w_fw[DATA_W-1:0];
                o_f_carry = w_fw[DATA_W];
            end
            SH_LSR: begin
                w_fw      = i_f_w >> i_f_fine;
                o_f_data  = w_fw[DATA_W:1];
                o_f_carry = w_fw[0];
            end
            SH_ASR: begin
                w_fw      = $signed(i_f_w) >>> i_f_fine;
                o_f_data  = w_fw[DATA_W:1];
                o_f_carry = w_fw[0];
            end
            default: begin
                o_f_data  = rotr(i_f_w[DATA_W-1:0], w_fine_ext);
                o_f_carry = o_f_data[DATA_W-1];
            end
        endcase
        if (i_f_ovr) begin
            o_f_data  = i_f_ovr_data;
            o_f_carry = i_f_ovr_c;
        end
    end

endmodule

// File: rtl/arm_shift_pipe.sv
// Operand-2 shifter pipeline: 1 or 2 stages with valid/ready on both sides
// and a flush that kills everything in flight.
module arm_shift_pipe
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_op,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_imm,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LOG_W  = $clog2(DATA_W);
    localparam int FINE_B = LOG_W / 2;

    typedef struct packed {
        logic [DATA_W:0]   w;
        shift_op_e         op;
        logic [FINE_B-1:0] fine;
        logic              ovr;
        logic [DATA_W-1:0] ovr_data;
        logic              ovr_c;
        logic [TAG_W-1:0]  tag;
    } mid_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic [TAG_W-1:0]  tag;
    } res_t;

    logic [DATA_W:0]   w_c_w;
    logic [FINE_B-1:0] w_c_fine;
    logic              w_c_ovr, w_c_ovr_c;
    logic [DATA_W-1:0] w_c_ovr_data, w_f_data;
    logic              w_f_carry;
    mid_t              w_c_mid, w_f_mid;
    res_t              w_res, r_out;
    logic              r_out_vld, w_load, w_src_vld;

    arm_shift_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_core (
        .i_c_data     (in_data),
        .i_c_op       (shift_op_e'(in_op)),
        .i_c_amt      (in_amt),
        .i_c_imm      (in_imm),
        .i_c_carry    (in_carry),
        .o_c_w        (w_c_w),
        .o_c_fine     (w_c_fine),
        .o_c_ovr      (w_c_ovr),
        .o_c_ovr_data (w_c_ovr_data),
        .o_c_ovr_c    (w_c_ovr_c),
        .i_f_w        (w_f_mid.w),
        .i_f_op       (w_f_mid.op),
        .i_f_fine     (w_f_mid.fine),
        .i_f_ovr      (w_f_mid.ovr),
        .i_f_ovr_data (w_f_mid.ovr_data),
        .i_f_ovr_c    (w_f_mid.ovr_c),
        .o_f_data     (w_f_data),
        .o_f_carry    (w_f_carry)
    );

    assign w_c_mid = '{w: w_c_w, op: shift_op_e'(in_op), fine: w_c_fine, ovr: w_c_ovr,
                       ovr_data: w_c_ovr_data, ovr_c: w_c_ovr_c, tag: in_tag};
    assign w_res   = '{data: w_f_data, carry: w_f_carry, tag: w_f_mid.tag};
    assign w_load  = !r_out_vld || out_ready;

    generate
        if (STAGES == 1) begin : g_one
            assign w_f_mid   = w_c_mid;
            assign w_src_vld = in_valid;
            assign in_ready  = flush || w_load;
        end else begin : g_two
            mid_t r_s1;
            logic r_s1_vld;

            assign w_f_mid   = r_s1;
            assign w_src_vld = r_s1_vld;
            // Flush drops whatever is presented, so never back-pressure it.
            assign in_ready  = flush || !r_s1_vld || w_load;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vld <= 1'b0;
                    r_s1     <= '0;
                end else if (flush) begin
                    r_s1_vld <= 1'b0;
                end else if (in_ready) begin
                    r_s1_vld <= in_valid;
                    if (in_valid) r_s1 <= w_c_mid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_load) begin
            r_out_vld <= w_src_vld;
            if (w_src_vld) r_out <= w_res;
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out.data;
    assign out_carry = r_out.carry;
    assign out_tag   = r_out.tag;

endmodule
